psum_serializer: RTL and testbench

Parallel-to-serial transmitter for PE output psums, the counterpart of the serial-to-parallel `shift_reg` receiver. It captures up to 24 parallel 16-bit psums, one per filter, in a single load cycle. It then streams `oc` of them onto one 16-bit line, one beat per accepted handshake. Lanes are sent highest index first, so a shifting receiver ends with lane i in its output i.

---
 rtl/psum_serializer.sv | 95 +++++++++
 tb/tb_psum_serializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/psum_serializer.sv
`default_nettype none
// ============================================================================
// Module      : psum_serializer
// Description : Captures up to MAX_OC parallel psums in one cycle and streams
//               them, highest lane first, onto a single valid/ready line.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_serializer #(
    parameter int DATA_W = 16,
    parameter int MAX_OC = 24,
    parameter int OC_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    output logic                     load_ready,
    input  logic [OC_W-1:0]          oc,
    input  logic [MAX_OC*DATA_W-1:0] d_in,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     done
);

    localparam logic [0:0]      S_IDLE   = 1'b0;
    localparam logic [0:0]      S_SEND   = 1'b1;
    localparam logic [OC_W-1:0] C_MAX_OC = OC_W'(MAX_OC);
    localparam logic [OC_W-1:0] C_ONE    = OC_W'(1);

    logic [0:0]                    state_q, state_d;
    logic [OC_W-1:0]               idx_q, idx_d;
    logic                          done_q, done_d;
    logic [MAX_OC-1:0][DATA_W-1:0] buf_q, buf_d;
    logic [OC_W-1:0]               w_n;

    // Oversized requests are clamped rather than flagged.
    assign w_n = (oc > C_MAX_OC) ? C_MAX_OC : oc;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    buf_d = d_in;
                    if (w_n == '0) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d   = w_n - C_ONE;
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q - C_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Payload needs no reset; out_data is masked whenever no beat is valid.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign load_ready = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_SEND);
    assign out_last   = out_valid && (idx_q == '0);
    assign out_data   = out_valid ? buf_q[idx_q] : '0;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_serializer
// Description : Directed self-checking bench for psum_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_serializer;

    localparam int DATA_W = 16;
    localparam int MAX_OC = 24;
    localparam int OC_W   = 5;

    logic                     clk;
    logic                     rst;
    logic                     load;
    logic                     load_ready;
    logic [OC_W-1:0]          oc;
    logic [MAX_OC*DATA_W-1:0] d_in;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     done;

    int nvec = 0;
    int nerr = 0;
    int xfer = 0;
    int base;
    logic [DATA_W-1:0] rx [MAX_OC];

    psum_serializer #(.DATA_W(DATA_W), .MAX_OC(MAX_OC), .OC_W(OC_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_ready (load_ready),
        .oc         (oc),
        .d_in       (d_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shifting receiver: new beat enters at 0, older beats move up.
    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            xfer <= xfer + 1;
            rx[0] <= out_data;
            for (int i = 1; i < MAX_OC; i++) rx[i] <= rx[i-1];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic fill(input logic [15:0] b);
        for (int i = 0; i < MAX_OC; i++) d_in[DATA_W*i +: DATA_W] = b + 16'(i);
    endtask

    task automatic beat(input string tag, input logic [15:0] data, input logic last);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"},  32'(out_data),  32'(data));
        check({tag, ".last"},  32'(out_last),  32'(last));
        check({tag, ".done"},  32'(done),      32'd0);
    endtask

    task automatic expect_done(input string tag);
        check({tag, ".done"},  32'(done),       32'd1);
        check({tag, ".valid"}, 32'(out_valid),  32'd0);
        check({tag, ".lrdy"},  32'(load_ready), 32'd1);
        check({tag, ".odata"}, 32'(out_data),   32'd0);
    endtask

    initial begin
        logic [6:0] pat;
        int e;
        rst = 1'b1; load = 1'b0; out_ready = 1'b0; oc = '0; d_in = '0;
        step(); step();
        check("rst.valid", 32'(out_valid),  32'd0);
        check("rst.last",  32'(out_last),   32'd0);
        check("rst.done",  32'(done),       32'd0);
        check("rst.data",  32'(out_data),   32'd0);
        check("rst.lrdy",  32'(load_ready), 32'd1);
        rst = 1'b0;
        step();

        // Basic frame
        d_in = '0;
        d_in[15:0] = 16'h0011; d_in[31:16] = 16'h0022; d_in[47:32] = 16'h0033;
        oc = 5'd3; load = 1'b1; out_ready = 1'b1;
        step(); load = 1'b0;
        check("basic.lrdy", 32'(load_ready), 32'd0);
        beat("basic.b0", 16'h0033, 1'b0); step();
        beat("basic.b1", 16'h0022, 1'b0); step();
        beat("basic.b2", 16'h0011, 1'b1); step();
        expect_done("basic.end"); step();
        check("basic.done_low", 32'(done), 32'd0);

        // Full width into receiver
        fill(16'h0100); oc = 5'd24; load = 1'b1; base = xfer;
        step(); load = 1'b0;
        for (int k = 0; k < 24; k++) begin
            check("full.data", 32'(out_data), 32'(16'h0117 - 16'(k)));
            check("full.last", 32'(out_last), 32'(k == 23));
            step();
        end
        expect_done("full.end");
        check("full.count", 32'(xfer - base), 32'd24);
        for (int i = 0; i < MAX_OC; i++) check("full.rx", 32'(rx[i]), 32'(16'h0100 + 16'(i)));
        step();

        // Backpressure with d_in churn
        fill(16'hA000); oc = 5'd4; load = 1'b1; out_ready = 1'b1; base = xfer;
        step(); load = 1'b0;
        pat = 7'b1101001; // applied LSB first: 1,0,0,1,0,1,1
        e = 3;
        for (int j = 0; j < 7; j++) begin
            beat("bp.beat", 16'hA000 + 16'(e), e == 0);
            d_in = {MAX_OC{16'h5A5A ^ 16'(j)}};
            out_ready = pat[j];
            step();
            if (pat[j] && e > 0) e--;
        end
        expect_done("bp.end");
        check("bp.count", 32'(xfer - base), 32'd4);
        out_ready = 1'b1;
        step();

        // oc = 0
        fill(16'h0700); oc = 5'd0; load = 1'b1;
        step(); load = 1'b0;
        expect_done("oc0.end");
        step();
        check("oc0.done_low", 32'(done), 32'd0);
        check("oc0.valid", 32'(out_valid), 32'd0);

        // oc = 31 clamps to 24
        fill(16'h0200); oc = 5'd31; load = 1'b1; base = xfer;
        step(); load = 1'b0;
        for (int k = 0; k < 24; k++) begin
            check("clamp.data", 32'(out_data), 32'(16'h0217 - 16'(k)));
            step();
        end
        expect_done("clamp.end");
        check("clamp.count", 32'(xfer - base), 32'd24);
        step();

        // oc = 1
        fill(16'hBEEF); oc = 5'd1; load = 1'b1;
        step(); load = 1'b0;
        beat("oc1.b0", 16'hBEEF, 1'b1); step();
        expect_done("oc1.end"); step();

        // Load during SEND is ignored; accepted again in the done cycle
        fill(16'h0300); oc = 5'd5; load = 1'b1;
        step();
        fill(16'h0400); oc = 5'd2;
        for (int k = 0; k < 5; k++) begin
            beat("ovl.beat", 16'h0304 - 16'(k), k == 4);
            step();
        end
        expect_done("ovl.end");
        step(); load = 1'b0;
        beat("ovl2.b0", 16'h0401, 1'b0); step();
        beat("ovl2.b1", 16'h0400, 1'b1); step();
        expect_done("ovl2.end"); step();

        // Reset mid-frame
        fill(16'h0500); oc = 5'd6; load = 1'b1;
        step(); load = 1'b0;
        beat("mid.b0", 16'h0505, 1'b0); step();
        beat("mid.b1", 16'h0504, 1'b0); step();
        rst = 1'b1;
        step(); rst = 1'b0;
        check("mid.valid", 32'(out_valid),  32'd0);
        check("mid.done",  32'(done),       32'd0);
        check("mid.lrdy",  32'(load_ready), 32'd1);
        check("mid.last",  32'(out_last),   32'd0);
        step();
        check("mid.done2", 32'(done), 32'd0);
        fill(16'h0600); oc = 5'd2; load = 1'b1;
        step(); load = 1'b0;
        beat("post.b0", 16'h0601, 1'b0); step();
        beat("post.b1", 16'h0600, 1'b1); step();
        expect_done("post.end"); step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
